// File: rtl/uart_rx_mmio_if.sv
// CPU-side bus of the memory-mapped UART receiver: pop/clear strobes in, head byte and status out.
// The master modport is the load/store side, the slave modport is the receiver.
interface uart_rx_mmio_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          rd_en;
    logic          clr_err;
    logic [7:0]    rd_data;
    logic          rx_valid;
    logic [CW-1:0] rx_count;
    logic          overrun;
    logic          frame_err;
    logic          parity_err;

    modport master (
        output rd_en, clr_err,
        input  rd_data, rx_valid, rx_count, overrun, frame_err, parity_err
    );

    modport slave (
        input  rd_en, clr_err,
        output rd_data, rx_valid, rx_count, overrun, frame_err, parity_err
    );
endinterface

// File: rtl/uart_rx_mmio.sv
// UART 8N1 receiver with FIFO and sticky status flags; define UART_RX_PARITY_EN for 8E1 frames.
// Byte visible one edge after the stop-bit sample; a full FIFO drops new bytes and sets overrun.
module uart_rx_mmio #(
    parameter int CLKS_PER_BIT = 1085,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          uart_rx,
    uart_rx_mmio_if.slave bus
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [BW-1:0] HALF_M1 = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] FULL_M1 = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic          sync1;
    logic          rxs;
    logic [2:0]    state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          par_bad;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic overrun_q;
    logic frame_err_q;

    logic bit_end;
    logic stop_sample;
    logic push_req;
    logic fifo_empty;
    logic fifo_full;
    logic do_push;
    logic do_pop;
    logic ovf_set;
    logic frame_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= uart_rx;
            rxs   <= sync1;
        end
    end

    assign bit_end = (baud_cnt == FULL_M1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    if (!rxs) state <= S_START;
                end
                S_START: begin
                    // Mid-bit check of the start bit rejects short glitches.
                    if (baud_cnt == HALF_M1) begin
                        baud_cnt <= '0;
                        if (!rxs) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shreg    <= {rxs, shreg[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    baud_cnt <= '0;
                end
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_bad <= 1'b0;
        end else if (state == S_IDLE) begin
            par_bad <= 1'b0;
        end else if (state == S_PARITY && bit_end) begin
            par_bad <= (rxs != ^shreg);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else if (stop_sample && par_bad) begin
            parity_err_q <= 1'b1;
        end else if (bus.clr_err) begin
            parity_err_q <= 1'b0;
        end
    end

    assign bus.parity_err = parity_err_q;
`else
    assign par_bad        = 1'b0;
    assign bus.parity_err = 1'b0;
`endif

    assign stop_sample = (state == S_STOP) && bit_end;
    assign push_req    = stop_sample && rxs && !par_bad;
    assign frame_set   = stop_sample && !rxs;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_C);
    assign do_pop     = bus.rd_en && !fifo_empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the byte.
    assign do_push    = push_req && (!fifo_full || do_pop);
    assign ovf_set    = push_req && fifo_full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (ovf_set)          overrun_q <= 1'b1;
            else if (bus.clr_err) overrun_q <= 1'b0;
            if (frame_set)        frame_err_q <= 1'b1;
            else if (bus.clr_err) frame_err_q <= 1'b0;
        end
    end

    assign bus.rd_data   = fifo_empty ? 8'h00 : mem[rd_ptr];
    assign bus.rx_valid  = !fifo_empty;
    assign bus.rx_count  = count;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_rx_mmio.sv
// Bench for uart_rx_mmio: table vectors, hand-written corner sequences and random frames vs a queue model.
module tb_uart_rx_mmio;
    localparam int C = 16;
    localparam int D = 8;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Cycle (relative to the start edge) in which the stop bit is sampled.
    localparam int SAMP = 2 + C / 2 + (NB - 1) * C;

    logic clk;
    logic rst;
    logic uart_rx;

    uart_rx_mmio_if #(.FIFO_DEPTH(D)) bus ();

    uart_rx_mmio #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .uart_rx (uart_rx),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    bit m_ovr, m_ferr, m_perr;

    typedef struct {
        logic [7:0] data;
        bit         stop;
        int         pops;
        bit         clr;
        int         exp_cnt;
        logic [7:0] exp_head;
        bit         exp_ferr;
    } vec_t;

    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string name);
        chk({name, "_count"}, 32'(bus.rx_count), q.size());
        chk({name, "_valid"}, 32'(bus.rx_valid), (q.size() != 0));
        chk({name, "_head"}, 32'(bus.rd_data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
        chk({name, "_ovr"}, 32'(bus.overrun), 32'(m_ovr));
        chk({name, "_ferr"}, 32'(bus.frame_err), 32'(m_ferr));
        chk({name, "_perr"}, 32'(bus.parity_err), 32'(m_perr));
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        uart_rx = 1'b1;
        bus.rd_en = 1'b0;
        bus.clr_err = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        q.delete();
        m_ovr = 0; m_ferr = 0; m_perr = 0;
    endtask

    task automatic clr_pulse();
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        m_ovr = 0; m_ferr = 0; m_perr = 0;
    endtask

    task automatic pop_chk();
        bus.rd_en = 1'b1;
        chk("pop_head", 32'(bus.rd_data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
        tick();
        bus.rd_en = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    // Sends one frame bit by bit; optional pop/clear strobes land on the stop-sample cycle.
    task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit par_flip,
                              input bit pop_s, input bit clr_s, input bit lat);
        logic [NB-1:0] bits;
        bit full, popped, good;
        bits = '0;
        bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
        bits[9] = (^b) ^ par_flip;
        good = stop_bit && !par_flip;
`else
        good = stop_bit;
`endif
        bits[NB-1] = stop_bit;
        for (int cyc = 0; cyc < NB * C; cyc++) begin
            uart_rx = bits[cyc / C];
            bus.rd_en = pop_s && (cyc == SAMP);
            bus.clr_err = clr_s && (cyc == SAMP);
            tick();
            if (lat && (cyc + 1 == SAMP)) chk("lat_before", 32'(bus.rx_count), q.size());
            if (lat && (cyc + 1 == SAMP + 1)) begin
                chk("lat_count", 32'(bus.rx_count), q.size() + 1);
                chk("lat_valid", 32'(bus.rx_valid), 1);
                chk("lat_data", 32'(bus.rd_data), (q.size() != 0) ? 32'(q[0]) : 32'(b));
            end
        end
        bus.rd_en = 1'b0;
        bus.clr_err = 1'b0;
        uart_rx = 1'b1;
        full = (q.size() == D);
        popped = pop_s && (q.size() != 0);
        if (popped) void'(q.pop_front());
        if (clr_s) begin m_ovr = 0; m_ferr = 0; m_perr = 0; end
        if (good) begin
            if (full && !popped) m_ovr = 1;
            else q.push_back(b);
        end
        if (!stop_bit) m_ferr = 1;
`ifdef UART_RX_PARITY_EN
        if (par_flip) m_perr = 1;
`endif
    endtask

    initial begin
        logic [7:0] bb;
        bit stp, flp, pp, cc;

        tbl[0] = '{8'hA5, 1'b1, 0, 1'b0, 1, 8'hA5, 1'b0};
        tbl[1] = '{8'h3C, 1'b0, 0, 1'b0, 1, 8'hA5, 1'b1};
        tbl[2] = '{8'h7E, 1'b1, 0, 1'b0, 2, 8'hA5, 1'b1};
        tbl[3] = '{8'h00, 1'b1, 1, 1'b1, 2, 8'h7E, 1'b0};
        tbl[4] = '{8'hFF, 1'b1, 2, 1'b0, 1, 8'hFF, 1'b0};
        tbl[5] = '{8'h55, 1'b1, 1, 1'b0, 1, 8'h55, 1'b0};

        do_reset();
        check_model("reset");

        for (int i = 0; i < 6; i++) begin
            repeat (tbl[i].pops) pop_chk();
            if (tbl[i].clr) clr_pulse();
            send_frame(tbl[i].data, tbl[i].stop, 1'b0, 1'b0, 1'b0, 1'b0);
            idle(C);
            chk($sformatf("tbl%0d_count", i), 32'(bus.rx_count), 32'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d_head", i), 32'(bus.rd_data), 32'(tbl[i].exp_head));
            chk($sformatf("tbl%0d_ferr", i), 32'(bus.frame_err), 32'(tbl[i].exp_ferr));
        end

        // Single byte with exact push latency, then pop to empty.
        do_reset();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_model("single");
        pop_chk();
        check_model("single_pop");

        // Nine back-to-back frames into an 8-deep FIFO.
        for (int i = 0; i < 9; i++) begin
            bb = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : (i == 2) ? 8'h55 : 8'($urandom);
            send_frame(bb, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle(C);
        check_model("full");
        repeat (D) pop_chk();
        check_model("drained");

        // Full FIFO with a pop on the push edge: no overrun, order kept across wrap.
        clr_pulse();
        for (int i = 0; i < D; i++) send_frame(8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(C);
        check_model("simul");
        repeat (D) pop_chk();
        check_model("simul_drained");

        // Clear strobe coinciding with a framing error: the set wins.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(C);
        chk("clr_vs_set_ferr", 32'(bus.frame_err), 1);
        check_model("clr_vs_set");
        send_frame(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(C);
        check_model("after_ferr");
        clr_pulse();
        check_model("ferr_cleared");

        // Three-cycle low glitch.
        uart_rx = 1'b0;
        repeat (3) tick();
        idle(3 * C);
        check_model("glitch");

        // Randomised traffic against the queue model.
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 2)) pop_chk();
            if ($urandom_range(0, 7) == 0) clr_pulse();
            stp = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
            flp = ($urandom_range(0, 7) == 0);
`else
            flp = 1'b0;
`endif
            pp = ($urandom_range(0, 7) == 0);
            cc = ($urandom_range(0, 15) == 0);
            send_frame(8'($urandom), stp, flp, pp, cc, 1'b0);
            idle(stp ? $urandom_range(0, 2) : C);
            check_model($sformatf("rnd%0d", i));
        end

`ifdef UART_RX_PARITY_EN
        clr_pulse();
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(C);
        chk("parity_err_set", 32'(bus.parity_err), 1);
        check_model("parity");
`endif

        // Reset in the middle of the data bits, then a clean frame.
        clr_pulse();
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        uart_rx = 1'b0;
        repeat (3 * C) tick();
        rst = 1'b1;
        uart_rx = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        m_ovr = 0; m_ferr = 0; m_perr = 0;
        check_model("midrst");
        idle(2 * C);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(C);
        check_model("after_rst");
        chk("after_rst_data", 32'(bus.rd_data), 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
